// File: rtl/ast_packet_gen.sv
// Avalon-ST traffic source: emits bursts of identical-length packets whose payload
// bytes follow a fixed pattern keyed by byte offset and packet number.
module ast_packet_gen #(
  parameter int AST_DWIDTH    = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int MIN_PCKT_SIZE = 60,
  parameter int MAX_PCKT_SIZE = 1514,
  parameter int IPG_CYCLES    = 2,
  localparam int SYM = AST_DWIDTH / 8,
  localparam int EW  = (SYM > 1) ? $clog2(SYM) : 1
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     start_i,
  input  logic [10:0]              len_i,
  input  logic [7:0]               pkt_cnt_i,
  input  logic [CHANNEL_WIDTH-1:0] channel_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [AST_DWIDTH-1:0]    ast_src_data_o,
  output logic                     ast_src_valid_o,
  input  logic                     ast_src_ready_i,
  output logic                     ast_src_sop_o,
  output logic                     ast_src_eop_o,
  output logic [EW-1:0]            ast_src_empty_o,
  output logic [CHANNEL_WIDTH-1:0] ast_src_channel_o
);

  localparam logic [10:0] MIN_LEN  = 11'(MIN_PCKT_SIZE);
  localparam logic [10:0] MAX_LEN  = 11'(MAX_PCKT_SIZE);
  localparam logic [7:0]  GAP_LAST = (IPG_CYCLES > 0) ? 8'(IPG_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  state_e                   state_q;
  logic [10:0]              len_q;
  logic [7:0]               cnt_q;
  logic [7:0]               pktIdx_q;
  logic [10:0]              beatIdx_q;
  logic [7:0]               gapCnt_q;
  logic [CHANNEL_WIDTH-1:0] chanCfg_q;
  logic                     valid_q, sop_q, eop_q, busy_q, done_q, err_q;
  logic [EW-1:0]            empty_q;
  logic [AST_DWIDTH-1:0]    data_q;
  logic [CHANNEL_WIDTH-1:0] chanOut_q;

  logic                     cmdBad, xfer, lastPkt, doLoad, doClear;
  logic [10:0]              ldLen, ldBeat;
  logic [3:0]               ldPkt;
  logic [CHANNEL_WIDTH-1:0] ldChan;
  logic [AST_DWIDTH-1:0]    ldData;
  logic                     ldSop, ldEop;
  logic [EW-1:0]            ldEmpty;

  function automatic logic [10:0] wordsOf(input logic [10:0] len);
    return 11'((int'(len) + SYM - 1) / SYM);
  endfunction

  function automatic logic [EW-1:0] emptyOf(input logic [10:0] len);
    return EW'((SYM - int'(len) % SYM) % SYM);
  endfunction

  // First symbol lands in the MSBs; symbols past the packet end stay zero.
  function automatic logic [AST_DWIDTH-1:0] genWord(input logic [3:0] pkt,
                                                    input logic [10:0] beat,
                                                    input logic [10:0] len);
    logic [AST_DWIDTH-1:0] w;
    logic [11:0]           kv;
    int                    k;
    w = '0;
    for (int s = 0; s < SYM; s++) begin
      k  = int'(beat) * SYM + s;
      kv = 12'(k);
      if (k < int'(len)) w[AST_DWIDTH-1-8*s -: 8] = {pkt, kv[3:0]} ^ kv[11:4];
    end
    return w;
  endfunction

  assign cmdBad  = (len_i < MIN_LEN) || (len_i > MAX_LEN) || (pkt_cnt_i == 8'd0);
  assign xfer    = valid_q && ast_src_ready_i;
  assign lastPkt = ((pktIdx_q + 8'd1) == cnt_q);

  // Selects which beat the output registers load next and precomputes its contents.
  always_comb begin
    ldLen   = len_q;
    ldPkt   = pktIdx_q[3:0];
    ldBeat  = '0;
    ldChan  = chanCfg_q;
    doLoad  = 1'b0;
    doClear = 1'b0;
    case (state_q)
      IDLE: begin
        ldLen  = len_i;
        ldPkt  = '0;
        ldChan = channel_i;
        doLoad = start_i && !cmdBad;
      end
      SEND: begin
        if (eop_q) ldPkt = pktIdx_q[3:0] + 4'd1;
        else       ldBeat = beatIdx_q + 11'd1;
        if (xfer) begin
          if (!eop_q)                           doLoad  = 1'b1;
          else if (!lastPkt && IPG_CYCLES == 0) doLoad  = 1'b1;
          else                                  doClear = 1'b1;
        end
      end
      GAP:     doLoad = (gapCnt_q == GAP_LAST);
      default: ;
    endcase
    ldData  = genWord(ldPkt, ldBeat, ldLen);
    ldSop   = (ldBeat == '0);
    ldEop   = (ldBeat == wordsOf(ldLen) - 11'd1);
    ldEmpty = ldEop ? emptyOf(ldLen) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      pktIdx_q  <= '0;
      beatIdx_q <= '0;
      gapCnt_q  <= '0;
      chanCfg_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      empty_q   <= '0;
      data_q    <= '0;
      chanOut_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && cmdBad) begin
            err_q <= 1'b1;
          end else if (start_i) begin
            len_q     <= len_i;
            cnt_q     <= pkt_cnt_i;
            chanCfg_q <= channel_i;
            pktIdx_q  <= '0;
            beatIdx_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (xfer && !eop_q) begin
            beatIdx_q <= ldBeat;
          end else if (xfer && lastPkt) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (xfer) begin
            pktIdx_q  <= pktIdx_q + 8'd1;
            beatIdx_q <= '0;
            gapCnt_q  <= '0;
            if (IPG_CYCLES != 0) state_q <= GAP;
          end
        end
        GAP: begin
          if (gapCnt_q == GAP_LAST) state_q <= SEND;
          else gapCnt_q <= gapCnt_q + 8'd1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (doLoad) begin
        valid_q   <= 1'b1;
        data_q    <= ldData;
        sop_q     <= ldSop;
        eop_q     <= ldEop;
        empty_q   <= ldEmpty;
        chanOut_q <= ldChan;
      end else if (doClear) begin
        valid_q   <= 1'b0;
        data_q    <= '0;
        sop_q     <= 1'b0;
        eop_q     <= 1'b0;
        empty_q   <= '0;
        chanOut_q <= '0;
      end
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign ast_src_valid_o   = valid_q;
  assign ast_src_data_o    = data_q;
  assign ast_src_sop_o     = sop_q;
  assign ast_src_eop_o     = eop_q;
  assign ast_src_empty_o   = empty_q;
  assign ast_src_channel_o = chanOut_q;

endmodule

// File: tb/tb_ast_packet_gen.sv
// Randomized self-checking bench for ast_packet_gen; a monitor reassembles packets
// and each test compares them against byte-level expectations built from the packet rules.
module tb_ast_packet_gen;

  localparam int DW  = 64;
  localparam int CW  = 1;
  localparam int SYM = DW / 8;
  localparam int EW  = 3;
  localparam int IPG = 2;

  logic          clk = 1'b0;
  logic          srst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [10:0]   len_i = '0;
  logic [7:0]    pkt_cnt_i = '0;
  logic [CW-1:0] channel_i = '0;
  logic          busy_o, done_o, err_o;
  logic [DW-1:0] data_o;
  logic          valid_o, sop_o, eop_o;
  logic          ready_i = 1'b1;
  logic [EW-1:0] empty_o;
  logic [CW-1:0] chan_o;

  always #5 clk = ~clk;

  ast_packet_gen #(
    .AST_DWIDTH(DW), .CHANNEL_WIDTH(CW), .MIN_PCKT_SIZE(60),
    .MAX_PCKT_SIZE(1514), .IPG_CYCLES(IPG)
  ) dut (
    .clk_i(clk), .srst_i(srst_i), .start_i(start_i), .len_i(len_i),
    .pkt_cnt_i(pkt_cnt_i), .channel_i(channel_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .ast_src_data_o(data_o),
    .ast_src_valid_o(valid_o), .ast_src_ready_i(ready_i),
    .ast_src_sop_o(sop_o), .ast_src_eop_o(eop_o),
    .ast_src_empty_o(empty_o), .ast_src_channel_o(chan_o)
  );

  int passCnt = 0;
  int totalCnt = 0;
  int mcyc = 0;
  bit randReady = 0;
  logic [CW-1:0] expChan = '0;

  logic [7:0] rxBytes[$];
  int rxLen[$], rxBeats[$], rxEmpty[$], rxSopCyc[$], rxEopCyc[$];
  int doneCyc[$], errCyc[$];
  int curBeats, curStart, stableViol, idleViol, midDrop, framingViol, chanViol;
  int busyCycles, validCycles, xferCnt;
  bit inPkt;
  logic pValid, pReady, pSop, pEop;
  logic [DW-1:0] pData;
  logic [EW-1:0] pEmpty;
  logic [CW-1:0] pChan;

  // Reference rules: byte pattern, word count and empty symbols from packet length.
  function automatic logic [7:0] exp_byte(input int p, input int k);
    return 8'((((p % 16) * 16) + (k % 16)) ^ (k / 16));
  endfunction

  function automatic int exp_words(input int len);
    return (len + SYM - 1) / SYM;
  endfunction

  function automatic int exp_empty(input int len);
    return (SYM - len % SYM) % SYM;
  endfunction

  function automatic int count_byte_errors(input int len, input int cnt);
    int bad = 0;
    int idx = 0;
    if (rxBytes.size() != len * cnt) return len * cnt + 1;
    for (int p = 0; p < cnt; p++)
      for (int k = 0; k < len; k++) begin
        if (rxBytes[idx] !== exp_byte(p, k)) bad++;
        idx++;
      end
    return bad;
  endfunction

  task automatic clear_rx();
    rxBytes.delete(); rxLen.delete(); rxBeats.delete(); rxEmpty.delete();
    rxSopCyc.delete(); rxEopCyc.delete(); doneCyc.delete(); errCyc.delete();
    curBeats = 0; curStart = 0; stableViol = 0; idleViol = 0; midDrop = 0;
    framingViol = 0; chanViol = 0; busyCycles = 0; validCycles = 0; xferCnt = 0;
    inPkt = 0; pValid = 0; pReady = 0; pSop = 0; pEop = 0; pData = '0;
    pEmpty = '0; pChan = '0;
  endtask

  // One clock of observation at the falling edge, then drive ready for this cycle.
  task automatic monitor_cycle();
    int plen;
    @(negedge clk);
    mcyc++;
    if (pValid && !pReady) begin
      if (!valid_o) stableViol++;
      else if (data_o !== pData || sop_o !== pSop || eop_o !== pEop ||
               empty_o !== pEmpty || chan_o !== pChan) stableViol++;
    end
    if (!valid_o && (data_o !== '0 || chan_o !== '0 || sop_o || eop_o || empty_o !== '0))
      idleViol++;
    if (inPkt && !valid_o) midDrop++;
    if (done_o) doneCyc.push_back(mcyc);
    if (err_o) errCyc.push_back(mcyc);
    if (busy_o) busyCycles++;
    if (valid_o) validCycles++;
    ready_i = randReady ? 1'($urandom_range(1, 0)) : 1'b1;
    if (valid_o && ready_i) begin
      xferCnt++;
      if (sop_o) begin
        if (inPkt) framingViol++;
        inPkt = 1;
        curBeats = 0;
        curStart = rxBytes.size();
        rxSopCyc.push_back(mcyc);
      end else if (!inPkt) framingViol++;
      if (!eop_o && empty_o !== '0) framingViol++;
      if (chan_o !== expChan) chanViol++;
      for (int s = 0; s < SYM; s++) rxBytes.push_back(data_o[DW-1-8*s -: 8]);
      curBeats++;
      if (eop_o) begin
        plen = curBeats * SYM - int'(empty_o);
        while (rxBytes.size() > curStart + plen) begin
          if (rxBytes[$] !== 8'h00) framingViol++;
          void'(rxBytes.pop_back());
        end
        rxLen.push_back(plen);
        rxBeats.push_back(curBeats);
        rxEmpty.push_back(int'(empty_o));
        rxEopCyc.push_back(mcyc);
        inPkt = 0;
      end
    end
    pValid = valid_o; pReady = ready_i; pData = data_o; pSop = sop_o;
    pEop = eop_o; pEmpty = empty_o; pChan = chan_o;
  endtask

  task automatic issue_start(input int len, input int cnt, input int ch, output int sc);
    start_i   = 1'b1;
    len_i     = 11'(len);
    pkt_cnt_i = 8'(cnt);
    channel_i = CW'(ch);
    expChan   = CW'(ch);
    sc        = mcyc;
    monitor_cycle();
    start_i   = 1'b0;
    len_i     = 11'($urandom);
    pkt_cnt_i = 8'($urandom);
    channel_i = CW'($urandom);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && doneCyc.size() == 0; i++) monitor_cycle();
    for (int i = 0; i < 3; i++) monitor_cycle();
  endtask

  task automatic test_reset();
    srst_i = 1'b1;
    monitor_cycle();
    monitor_cycle();
    totalCnt++; if ({valid_o, sop_o, eop_o, empty_o, chan_o, busy_o, done_o, err_o} !== '0) $display("[TB] FAIL reset_ctrl: got %b want 0", {valid_o, sop_o, eop_o, empty_o, chan_o, busy_o, done_o, err_o}); else passCnt++;
    totalCnt++; if (data_o !== '0) $display("[TB] FAIL reset_data: got %h want 0", data_o); else passCnt++;
    srst_i = 1'b0;
    monitor_cycle();
    clear_rx();
  endtask

  task automatic test_single();
    int sc;
    randReady = 0;
    clear_rx();
    issue_start(60, 1, 1, sc);
    wait_done(100);
    totalCnt++; if (rxSopCyc.size() != 1 || rxSopCyc[0] != sc + 1) $display("[TB] FAIL single_sop_cycle: got %0d want %0d", rxSopCyc.size() ? rxSopCyc[0] - sc : -1, 1); else passCnt++;
    totalCnt++; if (rxEopCyc.size() != 1 || rxEopCyc[0] != sc + 8) $display("[TB] FAIL single_eop_cycle: got %0d want %0d", rxEopCyc.size() ? rxEopCyc[0] - sc : -1, 8); else passCnt++;
    totalCnt++; if (rxEmpty.size() != 1 || rxEmpty[0] != exp_empty(60)) $display("[TB] FAIL single_empty: got %0d want %0d", rxEmpty.size() ? rxEmpty[0] : -1, exp_empty(60)); else passCnt++;
    totalCnt++; if (doneCyc.size() != 1 || doneCyc[0] != sc + 9) $display("[TB] FAIL single_done: got %0d pulses, first at +%0d want 1 at +9", doneCyc.size(), doneCyc.size() ? doneCyc[0] - sc : -1); else passCnt++;
    totalCnt++; if (count_byte_errors(60, 1) != 0) $display("[TB] FAIL single_bytes: got %0d bad want 0", count_byte_errors(60, 1)); else passCnt++;
    totalCnt++; if (busyCycles != 8) $display("[TB] FAIL single_busy: got %0d cycles want 8", busyCycles); else passCnt++;
    totalCnt++; if (xferCnt != exp_words(60)) $display("[TB] FAIL single_xfers: got %0d want %0d", xferCnt, exp_words(60)); else passCnt++;
    totalCnt++; if (framingViol + chanViol + idleViol + errCyc.size() != 0) $display("[TB] FAIL single_framing: got %0d issues want 0", framingViol + chanViol + idleViol + errCyc.size()); else passCnt++;
  endtask

  task automatic test_burst_1514();
    int sc;
    int gap;
    randReady = 0;
    clear_rx();
    issue_start(1514, 2, 0, sc);
    wait_done(1000);
    totalCnt++; if (rxBeats.size() != 2 || rxBeats[0] != 190 || rxBeats[1] != 190) $display("[TB] FAIL big_beats: got %0d packets first %0d want 2 of 190", rxBeats.size(), rxBeats.size() ? rxBeats[0] : -1); else passCnt++;
    totalCnt++; if (rxEmpty.size() != 2 || rxEmpty[0] != 6 || rxEmpty[1] != 6) $display("[TB] FAIL big_empty: got %0d want 6", rxEmpty.size() ? rxEmpty[0] : -1); else passCnt++;
    gap = (rxSopCyc.size() == 2 && rxEopCyc.size() >= 1) ? rxSopCyc[1] - rxEopCyc[0] - 1 : -1;
    totalCnt++; if (gap != IPG) $display("[TB] FAIL big_gap: got %0d idle cycles want %0d", gap, IPG); else passCnt++;
    totalCnt++; if (count_byte_errors(1514, 2) != 0) $display("[TB] FAIL big_bytes: got %0d bad want 0", count_byte_errors(1514, 2)); else passCnt++;
    totalCnt++; if (doneCyc.size() != 1) $display("[TB] FAIL big_done: got %0d pulses want 1", doneCyc.size()); else passCnt++;
  endtask

  task automatic test_backpressure();
    int sc;
    int badPkts = 0;
    randReady = 1;
    clear_rx();
    issue_start(64, 3, 1, sc);
    wait_done(500);
    randReady = 0;
    for (int p = 0; p < rxBeats.size(); p++)
      if (rxBeats[p] != 8 || rxEmpty[p] != 0) badPkts++;
    totalCnt++; if (stableViol != 0) $display("[TB] FAIL bp_stable: got %0d changes under stall want 0", stableViol); else passCnt++;
    totalCnt++; if (midDrop != 0) $display("[TB] FAIL bp_valid_drop: got %0d want 0", midDrop); else passCnt++;
    totalCnt++; if (xferCnt != 24) $display("[TB] FAIL bp_xfers: got %0d want 24", xferCnt); else passCnt++;
    totalCnt++; if (rxBeats.size() != 3 || badPkts != 0) $display("[TB] FAIL bp_shape: got %0d packets %0d malformed want 3 and 0", rxBeats.size(), badPkts); else passCnt++;
    totalCnt++; if (count_byte_errors(64, 3) != 0) $display("[TB] FAIL bp_bytes: got %0d bad want 0", count_byte_errors(64, 3)); else passCnt++;
    totalCnt++; if (doneCyc.size() != 1) $display("[TB] FAIL bp_done: got %0d pulses want 1", doneCyc.size()); else passCnt++;
  endtask

  task automatic test_reject();
    int lens[3];
    int cnts[3];
    int sc;
    lens[0] = 59;  cnts[0] = 1 + int'($urandom_range(9, 0));
    lens[1] = 1515; cnts[1] = 1 + int'($urandom_range(9, 0));
    lens[2] = 60 + int'($urandom_range(1454, 0)); cnts[2] = 0;
    randReady = 0;
    for (int i = 0; i < 3; i++) begin
      clear_rx();
      issue_start(lens[i], cnts[i], 1, sc);
      for (int c = 0; c < 4; c++) monitor_cycle();
      totalCnt++; if (errCyc.size() != 1 || errCyc[0] != sc + 1) $display("[TB] FAIL reject_err_%0d: got %0d pulses at +%0d want 1 at +1", i, errCyc.size(), errCyc.size() ? errCyc[0] - sc : -1); else passCnt++;
      totalCnt++; if (validCycles + busyCycles + doneCyc.size() != 0) $display("[TB] FAIL reject_quiet_%0d: got %0d active cycles want 0", i, validCycles + busyCycles + doneCyc.size()); else passCnt++;
    end
  endtask

  task automatic test_ignore_start();
    int sc;
    randReady = 0;
    clear_rx();
    issue_start(100, 2, 1, sc);
    for (int i = 0; i < 10; i++) monitor_cycle();
    start_i = 1'b1; len_i = 11'd59; pkt_cnt_i = 8'd5;
    monitor_cycle();
    start_i = 1'b0;
    for (int i = 0; i < 15; i++) monitor_cycle();
    start_i = 1'b1; len_i = 11'd200; pkt_cnt_i = 8'd1; channel_i = 1'b0;
    monitor_cycle();
    start_i = 1'b0;
    wait_done(300);
    totalCnt++; if (errCyc.size() != 0) $display("[TB] FAIL busy_start_err: got %0d pulses want 0", errCyc.size()); else passCnt++;
    totalCnt++; if (rxLen.size() != 2 || rxLen[0] != 100 || rxLen[1] != 100) $display("[TB] FAIL busy_start_lens: got %0d packets want 2 of 100", rxLen.size()); else passCnt++;
    totalCnt++; if (count_byte_errors(100, 2) + chanViol != 0) $display("[TB] FAIL busy_start_bytes: got %0d bad want 0", count_byte_errors(100, 2) + chanViol); else passCnt++;
    totalCnt++; if (doneCyc.size() != 1) $display("[TB] FAIL busy_start_done: got %0d pulses want 1", doneCyc.size()); else passCnt++;
  endtask

  task automatic test_reset_mid();
    int sc;
    randReady = 0;
    clear_rx();
    issue_start(1514, 1, 1, sc);
    for (int i = 0; i < 50 && xferCnt < 6; i++) monitor_cycle();
    srst_i = 1'b1;
    monitor_cycle();
    totalCnt++; if ({valid_o, sop_o, eop_o, empty_o, chan_o, busy_o, done_o, err_o} !== '0 || data_o !== '0) $display("[TB] FAIL midreset_outputs: got ctrl %b data %h want 0", {valid_o, sop_o, eop_o, empty_o, chan_o, busy_o, done_o, err_o}, data_o); else passCnt++;
    totalCnt++; if (rxEopCyc.size() != 0) $display("[TB] FAIL midreset_no_eop: got %0d eops want 0", rxEopCyc.size()); else passCnt++;
    srst_i = 1'b0;
    clear_rx();
    issue_start(60, 1, 0, sc);
    wait_done(100);
    totalCnt++; if (rxSopCyc.size() != 1 || rxSopCyc[0] != sc + 1) $display("[TB] FAIL midreset_restart_sop: got %0d want %0d", rxSopCyc.size() ? rxSopCyc[0] - sc : -1, 1); else passCnt++;
    totalCnt++; if (count_byte_errors(60, 1) != 0 || doneCyc.size() != 1) $display("[TB] FAIL midreset_restart_pkt: got %0d bad bytes %0d dones want 0 and 1", count_byte_errors(60, 1), doneCyc.size()); else passCnt++;
  endtask

  task automatic test_random();
    int sc, len, cnt, ch, badPkts;
    for (int b = 0; b < 4; b++) begin
      len = int'($urandom_range(260, 60));
      cnt = int'($urandom_range(3, 1));
      ch  = int'($urandom_range(1, 0));
      randReady = 1;
      clear_rx();
      issue_start(len, cnt, ch, sc);
      wait_done(3000);
      randReady = 0;
      badPkts = 0;
      for (int p = 0; p < rxBeats.size(); p++)
        if (rxBeats[p] != exp_words(len) || rxEmpty[p] != exp_empty(len)) badPkts++;
      totalCnt++; if (rxBeats.size() != cnt || badPkts != 0) $display("[TB] FAIL rand_shape_%0d: got %0d packets %0d malformed want %0d and 0 (len %0d)", b, rxBeats.size(), badPkts, cnt, len); else passCnt++;
      totalCnt++; if (count_byte_errors(len, cnt) != 0) $display("[TB] FAIL rand_bytes_%0d: got %0d bad want 0 (len %0d)", b, count_byte_errors(len, cnt), len); else passCnt++;
      totalCnt++; if (stableViol + midDrop + framingViol + chanViol + idleViol != 0 || doneCyc.size() != 1) $display("[TB] FAIL rand_protocol_%0d: got %0d issues %0d dones want 0 and 1", b, stableViol + midDrop + framingViol + chanViol + idleViol, doneCyc.size()); else passCnt++;
    end
  endtask

  initial begin
    clear_rx();
    test_reset();
    test_single();
    test_burst_1514();
    test_backpressure();
    test_reject();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/ast_packet_gen.md
Name: ast_packet_gen

Overview:
- Avalon-ST packet transmitter that builds test/traffic packets of programmable byte length and pushes them into the packet buffering/filtering path.
- Drives the src side of avalon_st_if and fully honours ready backpressure.
- Sends a burst of 1..255 identical-length packets per start command, with a programmable idle gap between packets.

Parameters:
- AST_DWIDTH, 64, data width in bits; multiple of 8; symbols per word SYM = AST_DWIDTH/8.
- CHANNEL_WIDTH, 1, channel field width.
- MIN_PCKT_SIZE, 60, smallest legal packet length in bytes.
- MAX_PCKT_SIZE, 1514, largest legal packet length in bytes.
- IPG_CYCLES, 2, idle cycles (valid low) between packets of a burst; 0 allowed.

Ports:
- clk_i  in  1  single clock; all logic on posedge.
- srst_i  in  1  synchronous reset, active-high.
- start_i  in  1  command strobe; sampled only in IDLE.
- len_i  in  11  packet length in bytes, captured on accepted start.
- pkt_cnt_i  in  8  packets in burst, captured on accepted start.
- channel_i  in  CHANNEL_WIDTH  channel value for the whole burst, captured on accepted start.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse after the last eop of a burst transfers.
- err_o  out  1  one-cycle pulse on a rejected start.
- ast_src_if  modport avalon_st_if.src  -  data[AST_DWIDTH], valid, ready (input), startofpacket, endofpacket, empty[$clog2(SYM)], channel[CHANNEL_WIDTH].

Behaviour:
- Reset: all outputs 0 (valid, sop, eop, empty, channel, data, busy, done, err); FSM returns to IDLE; any packet in flight is abandoned without eop.
- FSM states:
  - IDLE: on start_i, evaluate command.
    - Reject if len_i < MIN_PCKT_SIZE, len_i > MAX_PCKT_SIZE, or pkt_cnt_i == 0. Reject gives err_o = 1 next cycle and stays in IDLE.
    - Otherwise capture len, cnt and channel, then go to SEND.
  - SEND: valid = 1.
  - GAP: valid = 0 for IPG_CYCLES cycles, then back to SEND. With IPG_CYCLES = 0 the next sop follows the previous eop back-to-back.
  - DONE: done_o = 1 for one cycle, busy_o = 0 that cycle, then IDLE.
- Latency: start accepted at cycle N -> busy_o = 1 and valid = 1 with sop = 1 at N+1.
- Handshake: readyLatency 0. A beat transfers when valid & ready. While valid is high and ready is low, data, sop, eop, empty and channel are held stable. valid never drops mid-packet.
- Word count W = ceil(len/SYM) (60 -> 8, 64 -> 8, 1514 -> 190). Beat index counter is 0..W-1.
- sop = 1 only on beat 0; eop = 1 only on beat W-1.
- empty = (SYM - len mod SYM) mod SYM on the eop beat, 0 on all other beats.
- Payload:
  - Byte k of the packet (k = 0..len-1) = {pkt_idx[3:0], k[3:0]} ^ k[11:4], computed mod 256. pkt_idx is the 0-based packet number within the burst.
  - Byte 0 of each word is in data[AST_DWIDTH-1 -: 8] (first symbol in MSBs).
  - Bytes past len on the eop beat are 0.
- After the eop transfer:
  - If packets sent == cnt, go to DONE.
  - Otherwise go to GAP (or straight to SEND if IPG_CYCLES = 0) with pkt_idx + 1.
- start_i while busy_o = 1 is ignored: no err_o pulse, no effect on the burst.
- channel output equals the captured channel whenever valid = 1, and 0 otherwise. data is 0 when valid = 0.
- Counters sized for MAX_PCKT_SIZE and 255 packets; no wrap inside a legal burst.

Test Plan:
- len = 60, cnt = 1, ready = 1 constantly, start at N -> sop at N+1, 8 beats, eop at N+8 with empty = 4, done_o pulse at N+9; bytes 0..59 match the formula.
- len = 1514, cnt = 2, IPG = 2, ready = 1 -> each packet 190 beats, empty = 6; exactly 2 valid-low cycles between eop and the next sop; packet 2 bytes use pkt_idx = 1; single done_o.
- len = 64, cnt = 3, ready toggling pseudo-randomly -> no data/sop/eop/empty change while ready = 0; 8 beats per packet, empty = 0; total transfers = 24.
- start with len = 59, then 1515, then cnt = 0 -> err_o pulse one cycle after each start; valid stays 0; busy_o stays 0.
- Mid-burst start_i with len = 59 -> no err_o; burst continues unchanged.
- srst_i asserted on beat 5 of a 1514-byte packet -> next cycle all outputs 0, FSM in IDLE; a new start then gives a clean sop one cycle later.
